// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared definitions for the UART command-frame receiver: state encoding,
// error codes and the default sync byte.
package uart_rx_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_ADDR,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DRAIN
    } state_t;

    localparam logic [1:0] c_ERR_OVERRUN  = 2'b00;
    localparam logic [1:0] c_ERR_BAD_LEN  = 2'b01;
    localparam logic [1:0] c_ERR_BAD_CSUM = 2'b10;
    localparam logic [1:0] c_ERR_TIMEOUT  = 2'b11;

    localparam logic [7:0] c_SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_rx_frame_ctrl_buf.sv
// Payload buffer: p_DEPTH x 8 register array, synchronous write,
// combinational read by index.
module uart_frame_buf #(
    parameter int p_DEPTH = 16,
    parameter int p_IDX_W = 4
) (
    input  logic               i_Clk,
    input  logic               i_Wr_En,
    input  logic [p_IDX_W-1:0] i_Wr_Idx,
    input  logic [7:0]         i_Wr_Data,
    input  logic [p_IDX_W-1:0] i_Rd_Idx,
    output logic [7:0]         o_Rd_Data
);

    logic [7:0] r_mem [p_DEPTH];

    // NOTE: the array has no reset; only indices written by the current frame are ever read.
    always_ff @(posedge i_Clk) begin
        if (i_Wr_En) begin
            r_mem[i_Wr_Idx] <= i_Wr_Data;
        end
    end

    assign o_Rd_Data = r_mem[i_Rd_Idx];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frames the UART byte stream (sync, addr, len, payload, checksum), checks the
// sum and drains verified payload downstream over valid/ready.
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter logic [7:0] p_SYNC         = c_SYNC_DEFAULT,
    parameter int         p_MAX_LEN      = 16,
    parameter int         p_TIMEOUT_CLKS = 4340
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Out_Valid,
    output logic [7:0] o_Out_Byte,
    output logic       o_Out_Last,
    input  logic       i_Out_Ready,
    output logic [7:0] o_Frame_Addr,
    output logic [7:0] o_Frame_Len,
    output logic       o_Frame_Ok,
    output logic       o_Err,
    output logic [1:0] o_Err_Code,
    output logic       o_Busy
);

    localparam int c_IDX_W = (p_MAX_LEN > 1) ? $clog2(p_MAX_LEN) : 1;
    localparam int c_TMO_W = $clog2(p_TIMEOUT_CLKS + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(p_TIMEOUT_CLKS - 1);

    state_t             r_state,    w_state_nx;
    logic [7:0]         r_idx,      w_idx_nx;
    logic [7:0]         r_len,      w_len_nx;
    logic [7:0]         r_addr,     w_addr_nx;
    logic [7:0]         r_sum,      w_sum_nx;
    logic [c_TMO_W-1:0] r_tmo,      w_tmo_nx;
    logic               r_frame_ok, w_frame_ok_nx;
    logic               r_err,      w_err_nx;
    logic [1:0]         r_err_code, w_err_code_nx;

    logic       w_wr_en;
    logic [7:0] w_rd_data;
    logic [7:0] w_sum_byte;
    logic       w_last;
    logic       w_tmo_active;
    logic       w_timeout;

    uart_frame_buf #(
        .p_DEPTH (p_MAX_LEN),
        .p_IDX_W (c_IDX_W)
    ) u_buf (
        .i_Clk     (i_Clk),
        .i_Wr_En   (w_wr_en),
        .i_Wr_Idx  (r_idx[c_IDX_W-1:0]),
        .i_Wr_Data (i_Rx_Byte),
        .i_Rd_Idx  (r_idx[c_IDX_W-1:0]),
        .o_Rd_Data (w_rd_data)
    );

    assign w_sum_byte   = r_sum + i_Rx_Byte;
    assign w_last       = (r_idx == r_len - 8'd1);
    assign w_tmo_active = (r_state == ST_ADDR) || (r_state == ST_LEN) ||
                          (r_state == ST_PAYLOAD) || (r_state == ST_CSUM);
    // An arriving byte always beats an expiring timer.
    assign w_timeout    = w_tmo_active && !i_Rx_DV && (r_tmo == c_TMO_LAST);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nx    = r_state;
        w_idx_nx      = r_idx;
        w_len_nx      = r_len;
        w_addr_nx     = r_addr;
        w_sum_nx      = r_sum;
        w_tmo_nx      = '0;
        w_frame_ok_nx = 1'b0;
        w_err_nx      = 1'b0;
        w_err_code_nx = r_err_code;
        w_wr_en       = 1'b0;

        if (w_tmo_active && !i_Rx_DV && !w_timeout) begin
            w_tmo_nx = r_tmo + 1'b1;
        end

        if (w_timeout) begin
            w_err_nx      = 1'b1;
            w_err_code_nx = c_ERR_TIMEOUT;
            w_state_nx    = ST_HUNT;
        end else begin
            unique case (r_state)
                ST_HUNT: begin
                    if (i_Rx_DV && (i_Rx_Byte == p_SYNC)) begin
                        w_sum_nx   = 8'd0;
                        w_state_nx = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (i_Rx_DV) begin
                        w_addr_nx  = i_Rx_Byte;
                        w_sum_nx   = i_Rx_Byte;
                        w_state_nx = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (i_Rx_DV) begin
                        w_len_nx = i_Rx_Byte;
                        w_sum_nx = w_sum_byte;
                        if (i_Rx_Byte > 8'(p_MAX_LEN)) begin
                            w_err_nx      = 1'b1;
                            w_err_code_nx = c_ERR_BAD_LEN;
                            w_state_nx    = ST_HUNT;
                        end else if (i_Rx_Byte == 8'd0) begin
                            w_state_nx = ST_CSUM;
                        end else begin
                            w_idx_nx   = 8'd0;
                            w_state_nx = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (i_Rx_DV) begin
                        w_wr_en  = 1'b1;
                        w_sum_nx = w_sum_byte;
                        w_idx_nx = r_idx + 8'd1;
                        if (w_last) begin
                            w_state_nx = ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (i_Rx_DV) begin
                        if (w_sum_byte == 8'd0) begin
                            w_frame_ok_nx = 1'b1;
                            w_idx_nx      = 8'd0;
                            w_state_nx    = (r_len == 8'd0) ? ST_HUNT : ST_DRAIN;
                        end else begin
                            w_err_nx      = 1'b1;
                            w_err_code_nx = c_ERR_BAD_CSUM;
                            w_state_nx    = ST_HUNT;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (i_Out_Ready) begin
                        w_idx_nx = r_idx + 8'd1;
                        if (w_last) begin
                            w_state_nx = ST_HUNT;
                        end
                    end
                    if (i_Rx_DV) begin
                        w_err_nx      = 1'b1;
                        w_err_code_nx = c_ERR_OVERRUN;
                    end
                end
                default: w_state_nx = ST_HUNT;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state    <= ST_HUNT;
            r_idx      <= '0;
            r_len      <= '0;
            r_addr     <= '0;
            r_sum      <= '0;
            r_tmo      <= '0;
            r_frame_ok <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_idx      <= w_idx_nx;
            r_len      <= w_len_nx;
            r_addr     <= w_addr_nx;
            r_sum      <= w_sum_nx;
            r_tmo      <= w_tmo_nx;
            r_frame_ok <= w_frame_ok_nx;
            r_err      <= w_err_nx;
            r_err_code <= w_err_code_nx;
        end
    end

    assign o_Out_Valid  = (r_state == ST_DRAIN);
    assign o_Out_Byte   = o_Out_Valid ? w_rd_data : 8'd0;
    assign o_Out_Last   = o_Out_Valid && w_last;
    assign o_Frame_Addr = r_addr;
    assign o_Frame_Len  = r_len;
    assign o_Frame_Ok   = r_frame_ok;
    assign o_Err        = r_err;
    assign o_Err_Code   = r_err_code;
    assign o_Busy       = (r_state != ST_HUNT);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: expected beats, frame-ok and error
// events are queued as stimulus is driven and checked as the DUT emits them.
module tb_uart_rx_frame_ctrl;

    localparam int         c_MAX_LEN = 16;
    localparam int         c_TMO     = 4340;
    localparam logic [7:0] c_SYNC    = 8'hA5;

    logic       i_Clk = 1'b0;
    logic       i_Rst;
    logic       i_Rx_DV;
    logic [7:0] i_Rx_Byte;
    logic       o_Out_Valid;
    logic [7:0] o_Out_Byte;
    logic       o_Out_Last;
    logic       i_Out_Ready;
    logic [7:0] o_Frame_Addr;
    logic [7:0] o_Frame_Len;
    logic       o_Frame_Ok;
    logic       o_Err;
    logic [1:0] o_Err_Code;
    logic       o_Busy;

    uart_rx_frame_ctrl #(
        .p_SYNC         (c_SYNC),
        .p_MAX_LEN      (c_MAX_LEN),
        .p_TIMEOUT_CLKS (c_TMO)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .i_Rx_DV      (i_Rx_DV),
        .i_Rx_Byte    (i_Rx_Byte),
        .o_Out_Valid  (o_Out_Valid),
        .o_Out_Byte   (o_Out_Byte),
        .o_Out_Last   (o_Out_Last),
        .i_Out_Ready  (i_Out_Ready),
        .o_Frame_Addr (o_Frame_Addr),
        .o_Frame_Len  (o_Frame_Len),
        .o_Frame_Ok   (o_Frame_Ok),
        .o_Err        (o_Err),
        .o_Err_Code   (o_Err_Code),
        .o_Busy       (o_Busy)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] ok_q[$];
    logic [1:0]  err_q[$];
    logic [7:0]  tx[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic pulse_byte(input logic [7:0] b);
        i_Rx_DV   = 1'b1;
        i_Rx_Byte = b;
        tick();
        i_Rx_DV   = 1'b0;
        i_Rx_Byte = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b);
        pulse_byte(b);
        repeat (2) tick();
    endtask

    task automatic send_all();
        foreach (tx[i]) send_byte(tx[i]);
        tx.delete();
    endtask

    // Random payload with a correct (or deliberately corrupted) checksum.
    task automatic send_frame(input logic [7:0] addr, input logic [7:0] len, input bit bad);
        logic [7:0] sum;
        logic [7:0] b;
        sum = addr + len;
        send_byte(c_SYNC);
        send_byte(addr);
        send_byte(len);
        for (int i = 0; i < int'(len); i++) begin
            b   = 8'($urandom_range(0, 255));
            sum = sum + b;
            if (!bad) exp_q.push_back(beat_t'{data: b, last: (i == int'(len) - 1)});
            send_byte(b);
        end
        if (bad) err_q.push_back(2'b10);
        else     ok_q.push_back({addr, len});
        send_byte(bad ? (8'h01 - sum) : (8'h00 - sum));
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 400 && o_Busy; n++) tick();
        check(tag, o_Busy, 1'b0);
    endtask

    // Output monitor: sampled mid-cycle, well away from the active edge.
    always @(negedge i_Clk) begin
        if (!i_Rst) begin
            if (o_Out_Valid) begin
                if (exp_q.size() == 0) begin
                    check("out_valid_unexpected", o_Out_Valid, 1'b0);
                end else begin
                    check("out_byte", o_Out_Byte, exp_q[0].data);
                    check("out_last", o_Out_Last, exp_q[0].last);
                    if (i_Out_Ready) void'(exp_q.pop_front());
                end
            end
            if (o_Frame_Ok) begin
                if (ok_q.size() == 0) begin
                    check("frame_ok_unexpected", o_Frame_Ok, 1'b0);
                end else begin
                    check("frame_addr", o_Frame_Addr, ok_q[0][15:8]);
                    check("frame_len", o_Frame_Len, ok_q[0][7:0]);
                    void'(ok_q.pop_front());
                end
            end
            if (o_Err) begin
                if (err_q.size() == 0) begin
                    check("err_unexpected", o_Err, 1'b0);
                end else begin
                    check("err_code", o_Err_Code, err_q[0]);
                    void'(err_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_Rst       = 1'b1;
        i_Rx_DV     = 1'b0;
        i_Rx_Byte   = 8'h00;
        i_Out_Ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", o_Out_Valid, 1'b0);
        check("rst_byte", o_Out_Byte, 8'h00);
        check("rst_last", o_Out_Last, 1'b0);
        check("rst_addr", o_Frame_Addr, 8'h00);
        check("rst_len", o_Frame_Len, 8'h00);
        check("rst_ok", o_Frame_Ok, 1'b0);
        check("rst_err", o_Err, 1'b0);
        check("rst_code", o_Err_Code, 2'b00);
        check("rst_busy", o_Busy, 1'b0);
        i_Rst = 1'b0;
        tick();

        // 1: good frame, free-flowing drain
        ok_q.push_back({8'h10, 8'h02});
        exp_q.push_back(beat_t'{data: 8'h01, last: 1'b0});
        exp_q.push_back(beat_t'{data: 8'h02, last: 1'b1});
        tx = '{8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'hEB};
        send_all();
        wait_idle("t1_idle");
        check("t1_addr_held", o_Frame_Addr, 8'h10);

        // 2: bad checksum, then a good frame
        err_q.push_back(2'b10);
        tx = '{8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'hEC};
        send_all();
        check("t2_busy", o_Busy, 1'b0);
        send_frame(8'h33, 8'd4, 1'b0);
        wait_idle("t2_idle");

        // 3: over-length, zero-length, maximum length
        err_q.push_back(2'b01);
        tx = '{8'hA5, 8'h10, 8'h11};
        send_all();
        check("t3_badlen_busy", o_Busy, 1'b0);
        ok_q.push_back({8'h20, 8'h00});
        tx = '{8'hA5, 8'h20, 8'h00, 8'hE0};
        send_all();
        check("t3_zero_busy", o_Busy, 1'b0);
        send_frame(8'h7E, 8'(c_MAX_LEN), 1'b0);
        wait_idle("t3_max_idle");

        // 4: leading noise ignored, then inter-byte timeout
        send_byte(8'h00);
        send_byte(8'hFF);
        check("t4_noise_busy", o_Busy, 1'b0);
        pulse_byte(c_SYNC);
        pulse_byte(8'h10);
        repeat (c_TMO - 1) tick();
        check("t4_tmo_early", o_Err, 1'b0);
        check("t4_busy_before", o_Busy, 1'b1);
        err_q.push_back(2'b11);
        tick();
        check("t4_tmo_fire", o_Err, 1'b1);
        check("t4_tmo_code", o_Err_Code, 2'b11);
        check("t4_busy_after", o_Busy, 1'b0);
        tick();

        // 5: backpressure with an overrun byte mid-drain
        i_Out_Ready = 1'b0;
        send_frame(8'h44, 8'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            repeat (2) tick();
            if (k == 1) begin
                err_q.push_back(2'b00);
                pulse_byte(8'h5A);
            end else begin
                tick();
            end
            repeat (2) tick();
            check("t5_held_valid", o_Out_Valid, 1'b1);
            i_Out_Ready = 1'b1;
            tick();
            i_Out_Ready = 1'b0;
        end
        wait_idle("t5_idle");
        check("t5_all_drained", exp_q.size(), 0);

        // 6: reset after the first transfer, then a clean frame from index 0
        send_frame(8'h55, 8'd3, 1'b0);
        repeat (2) tick();
        i_Out_Ready = 1'b1;
        tick();
        i_Out_Ready = 1'b0;
        i_Rst       = 1'b1;
        tick();
        i_Rst       = 1'b0;
        check("t6_valid", o_Out_Valid, 1'b0);
        check("t6_busy", o_Busy, 1'b0);
        check("t6_addr_cleared", o_Frame_Addr, 8'h00);
        exp_q.delete();
        i_Out_Ready = 1'b1;
        send_frame(8'h66, 8'd3, 1'b0);
        wait_idle("t6_idle");

        repeat (3) tick();
        check("end_exp_q", exp_q.size(), 0);
        check("end_ok_q", ok_q.size(), 0);
        check("end_err_q", err_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Sequences the byte stream from the UART receiver into checked command frames.
- Frame format: sync byte, address byte, length byte, payload bytes (count given by the length byte), checksum byte.
- Buffers the payload and drains it to downstream logic over a valid/ready handshake, only after the checksum passes.
- Sits between the UART receiver's byte-valid/byte outputs and the register or command logic.

Parameters:
p_SYNC, 8'hA5, frame start byte
p_MAX_LEN, 16, maximum payload bytes; also the buffer depth (1..255)
p_TIMEOUT_CLKS, 4340, maximum idle clocks between bytes inside a frame (about 2 byte times at 217 clks/bit)

Ports:
i_Clk  in  1  clock
i_Rst  in  1  synchronous active-high reset
i_Rx_DV  in  1  one-cycle pulse: i_Rx_Byte is valid
i_Rx_Byte  in  8  received byte
o_Out_Valid  out  1  payload byte available
o_Out_Byte  out  8  payload byte
o_Out_Last  out  1  current byte is the last payload byte of the frame
i_Out_Ready  in  1  downstream accepts the byte
o_Frame_Addr  out  8  address of the current frame; stable from the o_Frame_Ok pulse until the next frame's address byte
o_Frame_Len  out  8  payload length of the current frame
o_Frame_Ok  out  1  one-cycle pulse: checksum passed
o_Err  out  1  one-cycle pulse: error; code on o_Err_Code
o_Err_Code  out  2  00 overrun, 01 bad length, 10 bad checksum, 11 timeout
o_Busy  out  1  high in every state except HUNT

Behaviour:
- Reset (i_Rst high at a clock edge): state HUNT; all outputs 0; buffer index, timeout counter and checksum accumulator 0. Applies mid-frame and mid-drain; any partial frame is discarded with no error pulse.
- A byte is consumed on any clock where i_Rx_DV=1. Each step below occurs on that edge.
- States:
  - HUNT: byte == p_SYNC -> ADDR, clear checksum. Any other byte is ignored, with no error.
  - ADDR: latch address, sum = byte -> LEN.
  - LEN:
    - len > p_MAX_LEN -> o_Err code 01, go to HUNT.
    - len == 0 -> CSUM.
    - otherwise -> PAYLOAD, index 0.
    - sum += byte in all cases.
  - PAYLOAD: buf[index] <= byte; sum += byte; index++; after byte len-1 -> CSUM.
  - CSUM: (sum + byte) mod 256 == 0 -> pass; otherwise o_Err code 10 and go to HUNT.
    - Pass with len > 0: o_Frame_Ok pulses next cycle, state DRAIN, index 0.
    - Pass with len == 0: o_Frame_Ok pulses next cycle, state HUNT, no o_Out_Valid.
  - DRAIN:
    - o_Out_Valid=1, o_Out_Byte=buf[index], o_Out_Last=(index==len-1).
    - Transfer on o_Out_Valid & i_Out_Ready; index++ on each transfer.
    - After the last transfer: o_Out_Valid=0 next cycle, state HUNT.
    - While i_Out_Ready=0, o_Out_Byte and o_Out_Last hold.
- Arithmetic: sum is 8-bit and wraps modulo 256.
- Latency: first o_Out_Valid and o_Frame_Ok are asserted 1 cycle after the edge that consumes the checksum byte.
- Timeout:
  - The counter runs in ADDR, LEN, PAYLOAD and CSUM only, and clears on every consumed byte.
  - When it reaches p_TIMEOUT_CLKS-1: o_Err code 11, go to HUNT.
  - If a byte arrives in the same cycle, the byte wins: it is consumed and no timeout fires.
- Overrun: a byte consumed during DRAIN is dropped, o_Err pulses code 00, and draining continues unaffected.
- At most one error pulse per cycle. o_Err_Code holds its last value between pulses.
- The buffer is not cleared between frames; only indices 0..len-1 are ever presented.

Decomposition:
- Shared package: state encodings (HUNT, ADDR, LEN, PAYLOAD, CSUM, DRAIN), the error code constants, and a p_SYNC default.
- One sub-module is natural: uart_frame_buf, a p_MAX_LEN x 8 register array with synchronous write and combinational read by index.

Test Plan:
1. Good frame A5 10 02 01 02 EB, i_Out_Ready=1 -> o_Frame_Ok pulse; o_Frame_Addr=10; o_Out_Byte 01 then 02 on consecutive cycles; o_Out_Last only with 02; state returns to HUNT.
2. Bad checksum A5 10 02 01 02 EC -> o_Err code 10; no o_Out_Valid; a following good frame is accepted normally.
3. Over-length and zero-length:
   - A5 10 11 with p_MAX_LEN=16 -> o_Err code 01 at the length byte.
   - A5 20 00 E0 -> o_Frame_Ok pulse; no o_Out_Valid.
4. Timeout and noise: A5 10 then silence for p_TIMEOUT_CLKS -> o_Err code 11 and state HUNT; leading bytes 00 FF before A5 are ignored with no error.
5. Backpressure and overrun: good 3-byte frame with i_Out_Ready low for 5 cycles per byte -> byte held stable; a byte arriving during DRAIN -> o_Err code 00, all 3 payload bytes still delivered.
6. Reset mid-drain: i_Rst asserted after the first transfer -> next cycle o_Out_Valid=0, o_Busy=0; a subsequent frame drains from index 0.
